// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS memory responder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mips_mem_pkg;

  // Four 8-bit lanes; lane 0 is the most significant byte (big-endian).
  typedef logic [0:3][7:0] byte_lanes_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  function automatic logic [31:0] lanes_to_word(input byte_lanes_t lanes);
    return {lanes[0], lanes[1], lanes[2], lanes[3]};
  endfunction

  function automatic byte_lanes_t word_to_lanes(input logic [31:0] word);
    byte_lanes_t lanes;
    lanes[0] = word[31:24];
    lanes[1] = word[23:16];
    lanes[2] = word[15:8];
    lanes[3] = word[7:0];
    return lanes;
  endfunction

endpackage

// File: rtl/mips_mem_bank.sv
// Word storage: DEPTH_WORDS x 32, one synchronous write port, two combinational reads.
// Latency: write commits at the rising edge; reads are zero-latency (read-before-write).
// Backpressure: none; every write strobe is accepted.
//
// Ports:
//   clk               rising-edge clock
//   we, waddr, wdata  write port
//   raddr_a, rdata_a  read port A (instruction side)
//   raddr_b, rdata_b  read port B (data side)
module mips_mem_bank #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [31:0]                    wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_a,
  output logic [31:0]                    rdata_a,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_b,
  output logic [31:0]                    rdata_b
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the MIPS core: combinational fetch/load, clocked byte-lane stores.
// Latency: reads zero-cycle; stores commit at the next edge; DEPTH_WORDS-cycle clear after reset.
// Backpressure: none; stores during the clear sweep or failing checks are dropped.
//
// Ports:
//   clk, rst_b                  clock, synchronous active-high reset
//   inst_addr / inst            instruction fetch address and word
//   mem_addr                    data byte address
//   mem_data_in / mem_data_out  store / load lanes (lane 0 = MSB)
//   mem_write_en                store request this cycle
//   init_done                   clear sweep finished
//   misalign_err, range_err     sticky error flags
//   store_count                 saturating count of committed stores
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst,
  input  logic [31:0] mem_addr,
  input  byte_lanes_t mem_data_in,
  output byte_lanes_t mem_data_out,
  input  logic        mem_write_en,
  output logic        init_done,
  output logic        misalign_err,
  output logic        range_err,
  output logic [31:0] store_count
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);

  // In range iff every bit above the word index and byte offset is zero.
  function automatic logic in_range(input logic [31:0] addr);
    return (addr >> (ADDR_W + 2)) == 32'd0;
  endfunction

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q;
  logic              init_done_q;
  logic              misalign_q;
  logic              range_q;
  logic [31:0]       store_count_q;

  logic              ready;
  logic              inst_ok;
  logic              mem_ok;
  logic              mem_aligned;
  logic              commit;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [31:0]       bank_wdata;
  logic [31:0]       rdata_inst;
  logic [31:0]       rdata_mem;
  logic              unused_inst_lo;

  // Byte offset of the fetch address has no effect on reads.
  assign unused_inst_lo = ^inst_addr[1:0];

  assign ready       = (state_q == READY);
  assign inst_ok     = in_range(inst_addr);
  assign mem_ok      = in_range(mem_addr);
  assign mem_aligned = (mem_addr[1:0] == 2'b00);

  // Reset on the same edge suppresses any write so reset always wins.
  assign commit     = ready && mem_write_en && mem_ok && mem_aligned && !rst_b;
  assign bank_we    = !rst_b && ((state_q == CLEAR) || commit);
  assign bank_waddr = ready ? mem_addr[ADDR_W+1:2] : clr_idx_q;
  assign bank_wdata = ready ? lanes_to_word(mem_data_in) : 32'd0;

  mips_mem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk     (clk),
    .we      (bank_we),
    .waddr   (bank_waddr),
    .wdata   (bank_wdata),
    .raddr_a (inst_addr[ADDR_W+1:2]),
    .rdata_a (rdata_inst),
    .raddr_b (mem_addr[ADDR_W+1:2]),
    .rdata_b (rdata_mem)
  );

  // Reads are forced to zero while clearing and for out-of-range addresses,
  // so stale or uninitialised contents never leak out.
  assign inst         = (ready && inst_ok) ? rdata_inst : 32'd0;
  assign mem_data_out = (ready && mem_ok) ? word_to_lanes(rdata_mem) : word_to_lanes(32'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_idx_q == LAST_IDX) state_d = READY;
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q       <= CLEAR;
      clr_idx_q     <= '0;
      init_done_q   <= 1'b0;
      misalign_q    <= 1'b0;
      range_q       <= 1'b0;
      store_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) begin
        clr_idx_q <= clr_idx_q + 1'b1;
        if (state_d == READY) init_done_q <= 1'b1;
      end
      if (ready) begin
        // Reads happen every cycle, so any out-of-range address is an access.
        if (!inst_ok || !mem_ok) range_q <= 1'b1;
        if (mem_write_en && !mem_aligned) misalign_q <= 1'b1;
        if (commit && (store_count_q != 32'hFFFF_FFFF)) begin
          store_count_q <= store_count_q + 32'd1;
        end
      end
    end
  end

  assign init_done    = init_done_q;
  assign misalign_err = misalign_q;
  assign range_err    = range_q;
  assign store_count  = store_count_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder (DEPTH_WORDS = 1024).
// Latency: n/a.
// Backpressure: n/a.
module tb_mips_mem_responder;
  import mips_mem_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic [31:0] mem_addr;
  byte_lanes_t mem_data_in;
  byte_lanes_t mem_data_out;
  logic        mem_write_en;
  logic        init_done;
  logic        misalign_err;
  logic        range_err;
  logic [31:0] store_count;

  int n_checks = 0;
  int n_fail   = 0;

  mips_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .inst_addr    (inst_addr),
    .inst         (inst),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_write_en (mem_write_en),
    .init_done    (init_done),
    .misalign_err (misalign_err),
    .range_err    (range_err),
    .store_count  (store_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one store for one edge, then drop the strobe.
  task automatic store(input logic [31:0] addr, input logic [31:0] word);
    mem_addr     = addr;
    mem_data_in  = word_to_lanes(word);
    mem_write_en = 1'b1;
    tick();
    mem_write_en = 1'b0;
  endtask

  task automatic sweep_wait(output int n);
    n = 0;
    while (!init_done && n < 3000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int bad_read;

    rst_b        = 1'b1;
    inst_addr    = 32'hFFC;
    mem_addr     = 32'h0;
    mem_data_in  = word_to_lanes(32'h0);
    mem_write_en = 1'b0;
    tick();
    tick();
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_misalign",  {31'd0, misalign_err}, 32'd0);
    check("rst_range",     {31'd0, range_err}, 32'd0);
    check("rst_count",     store_count, 32'd0);

    // Sweep with a store attempt at cycle 5 that must be dropped.
    rst_b    = 1'b0;
    n        = 0;
    bad_read = 0;
    while (!init_done && n < 3000) begin
      if (inst !== 32'd0 || lanes_to_word(mem_data_out) !== 32'd0) bad_read++;
      if (n == 5) begin
        mem_addr     = 32'h10;
        mem_data_in  = word_to_lanes(32'hDEADBEEF);
        mem_write_en = 1'b1;
      end else begin
        mem_addr     = 32'h0;
        mem_write_en = 1'b0;
      end
      tick();
      n++;
    end
    mem_write_en = 1'b0;
    check("sweep_len",   n, DEPTH);
    check("clear_reads", bad_read, 32'd0);
    mem_addr = 32'h10;
    #1;
    check("clr_store_dropped", lanes_to_word(mem_data_out), 32'd0);
    check("clr_store_count",   store_count, 32'd0);

    // Same-word read-before-write.
    inst_addr    = 32'h20;
    mem_addr     = 32'h20;
    mem_data_in  = word_to_lanes(32'h12345678);
    mem_write_en = 1'b1;
    #1;
    check("rbw_old", inst, 32'd0);
    tick();
    mem_write_en = 1'b0;
    check("rbw_new", inst, 32'h12345678);
    mem_addr = 32'h22;
    #1;
    check("rd_offset_ignored", lanes_to_word(mem_data_out), 32'h12345678);
    check("count_after_1", store_count, 32'd1);

    // Misaligned store is suppressed.
    store(32'h21, 32'hAABBCCDD);
    check("misalign_word",  inst, 32'h12345678);
    check("misalign_flag",  {31'd0, misalign_err}, 32'd1);
    check("misalign_range", {31'd0, range_err}, 32'd0);
    check("misalign_count", store_count, 32'd1);

    store(32'h24, 32'h01020304);
    mem_addr = 32'h24;
    #1;
    check("aligned_word",   lanes_to_word(mem_data_out), 32'h01020304);
    check("misalign_sticky", {31'd0, misalign_err}, 32'd1);
    check("count_after_2",  store_count, 32'd2);

    // Out-of-range store and read.
    mem_addr     = 32'h1000;
    mem_data_in  = word_to_lanes(32'h55667788);
    mem_write_en = 1'b1;
    #1;
    check("oor_read", lanes_to_word(mem_data_out), 32'd0);
    tick();
    mem_write_en = 1'b0;
    check("oor_flag",  {31'd0, range_err}, 32'd1);
    check("oor_count", store_count, 32'd2);
    mem_addr = 32'h0;
    #1;
    check("oor_no_alias", lanes_to_word(mem_data_out), 32'd0);
    store(32'hFFC, 32'hCAFEF00D);
    mem_addr = 32'hFFC;
    #1;
    check("top_word",        lanes_to_word(mem_data_out), 32'hCAFEF00D);
    check("count_after_3",   store_count, 32'd3);
    check("range_sticky",    {31'd0, range_err}, 32'd1);

    // Data at 0x8, then reset with a store on the same edge, then reset mid-sweep.
    store(32'h8, 32'h11223344);
    mem_addr = 32'h8;
    #1;
    check("pre_reset_word", lanes_to_word(mem_data_out), 32'h11223344);
    rst_b        = 1'b1;
    mem_addr     = 32'h30;
    mem_data_in  = word_to_lanes(32'h99999999);
    mem_write_en = 1'b1;
    tick();
    rst_b        = 1'b0;
    mem_write_en = 1'b0;
    check("rst2_count",    store_count, 32'd0);
    check("rst2_init",     {31'd0, init_done}, 32'd0);
    check("rst2_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst2_range",    {31'd0, range_err}, 32'd0);
    mem_addr = 32'h8;
    for (int i = 0; i < 100; i++) tick();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("midsweep_init", {31'd0, init_done}, 32'd0);
    sweep_wait(n);
    check("restart_len", n, DEPTH);
    check("old_data_cleared", lanes_to_word(mem_data_out), 32'd0);

    // Misaligned and out of range together.
    store(32'h1001, 32'h0BADF00D);
    check("both_misalign", {31'd0, misalign_err}, 32'd1);
    check("both_range",    {31'd0, range_err}, 32'd1);
    check("both_count",    store_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
